// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM encoding and decode helpers for the memory access unit.
// LWL/LWR acceptance is controlled by MEM_ACCESS_UNALIGNED_EN in mem_access_unit.
package mem_access_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWU = 4'd5,
        OP_LD  = 4'd6,
        OP_SB  = 4'd7,
        OP_SH  = 4'd8,
        OP_SW  = 4'd9,
        OP_SD  = 4'd10,
        OP_LWL = 4'd11,
        OP_LWR = 4'd12
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_w_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Access size in bytes; 0 marks an undefined op code.
    function automatic logic [3:0] op_bytes(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB:                     return 4'd1;
            OP_LH, OP_LHU, OP_SH:                     return 4'd2;
            OP_LW, OP_LWU, OP_SW, OP_LWL, OP_LWR:     return 4'd4;
            OP_LD, OP_SD:                             return 4'd8;
            default:                                  return 4'd0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW};
    endfunction

    function automatic logic op_is_partial(input logic [3:0] op);
        return op inside {OP_LWL, OP_LWR};
    endfunction

    // LWU only makes sense when the register is wider than a word.
    function automatic logic op_fits(input logic [3:0] op, input int data_w);
        return (op_bytes(op) != 4'd0) && (8 * int'(op_bytes(op)) <= data_w) &&
               !((op == OP_LWU) && (data_w == 32));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane steering: store placement, load extraction and
// extension, and the LWL/LWR word merge (sign-extended from bit 31).
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int LANES  = lanes_of(DATA_W),
    localparam int OFF_W  = off_w_of(DATA_W)
) (
    input  logic [3:0]        op,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic [31:0]       rt,
    output logic [LANES-1:0]  byteenable,
    output logic [DATA_W-1:0] wdata_lane,
    output logic [DATA_W-1:0] load_data
);

    localparam logic [DATA_W-1:0] ONES = '1;

    int o, n, wb, b, sh;
    logic [DATA_W-1:0] lowmask, raw, tmp;
    logic [31:0] word, merged;

    always_comb begin
        o          = int'(off);
        n          = int'(op_bytes(op));
        wb         = o & ~3;
        b          = o & 3;
        sh         = DATA_W - 8 * (o + n);
        lowmask    = '0;
        raw        = '0;
        tmp        = '0;
        word       = '0;
        merged     = '0;
        byteenable = '0;
        wdata_lane = '0;
        load_data  = '0;
        if (op_is_partial(op)) begin
            tmp  = rdata >> (DATA_W - 32 - 8 * wb);
            word = tmp[31:0];
            if (op == OP_LWL) begin
                merged = (word << (8 * b)) | (rt & ((32'h1 << (8 * b)) - 32'h1));
                for (int k = 0; k < LANES; k++) byteenable[k] = (k >= o) && (k < wb + 4);
            end else begin
                merged = (word >> (8 * (3 - b))) | (rt & ~(32'hFFFF_FFFF >> (8 * (3 - b))));
                for (int k = 0; k < LANES; k++) byteenable[k] = (k >= wb) && (k <= o);
            end
            load_data       = {DATA_W{merged[31]}};
            load_data[31:0] = merged;
        end else if ((n != 0) && (8 * n <= DATA_W) && (o + n <= LANES)) begin
            // Lowest lane holds the most significant byte, so shift toward the MSB end.
            lowmask = ONES >> (DATA_W - 8 * n);
            for (int k = 0; k < LANES; k++) byteenable[k] = (k >= o) && (k < o + n);
            wdata_lane = (wdata & lowmask) << sh;
            raw        = (rdata >> sh) & lowmask;
            load_data  = (op_is_signed(op) && raw[8 * n - 1]) ? (raw | ~lowmask) : raw;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Core-to-bus load/store unit: IDLE -> ISSUE -> RESP with alignment checking.
// Define MEM_ACCESS_UNALIGNED_EN to accept LWL/LWR; otherwise they return resp_err.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  ADDR_W = 32,
    localparam int LANES  = lanes_of(DATA_W),
    localparam int OFF_W  = off_w_of(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_rt,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LANES-1:0]  mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_readdata
);

`ifdef MEM_ACCESS_UNALIGNED_EN
    localparam logic PARTIAL_EN = 1'b1;
`else
    localparam logic PARTIAL_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [31:0]       rt_q, rt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic [OFF_W-1:0]  req_off;
    logic [3:0]        req_bytes;
    logic              req_bad;
    logic              accept;
    logic [3:0]        al_op;
    logic [OFF_W-1:0]  al_off;
    logic [LANES-1:0]  al_be;
    logic [DATA_W-1:0] al_wdata, al_load;

    // Only the low word of rt takes part in the LWL/LWR merge.
    if (DATA_W > 32) begin : g_rt_hi
        logic unused_rt_hi;
        assign unused_rt_hi = ^req_rt[DATA_W-1:32];
    end

    assign req_off   = req_addr[OFF_W-1:0];
    assign req_bytes = op_bytes(req_op);
    assign req_ready = (state_q == S_IDLE) && reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_bad = !op_fits(req_op, DATA_W);
        if (op_is_partial(req_op)) begin
            req_bad = !PARTIAL_EN;
        end else if (|(req_off & OFF_W'(req_bytes - 4'd1))) begin
            req_bad = 1'b1;
        end
    end

    // The aligner steers the incoming store in IDLE and extracts the load in ISSUE.
    assign al_op  = (state_q == S_IDLE) ? req_op  : op_q;
    assign al_off = (state_q == S_IDLE) ? req_off : off_q;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .op         (al_op),
        .off        (al_off),
        .wdata      (req_wdata),
        .rdata      (mem_readdata),
        .rt         (rt_q),
        .byteenable (al_be),
        .wdata_lane (al_wdata),
        .load_data  (al_load)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        rt_d        = rt_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        addr_d      = addr_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d        = req_op;
                    off_d       = req_off;
                    rt_d        = req_rt[31:0];
                    wdata_d     = op_is_store(req_op) ? al_wdata : '0;
                    addr_d      = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    err_d       = req_bad;
                    resp_data_d = '0;
                    state_d     = req_bad ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_waitrequest) begin
                    resp_data_d = op_is_store(op_q) ? '0 : al_load;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            off_q       <= '0;
            rt_q        <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rt_q        <= rt_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
        end
    end

    assign mem_read       = (state_q == S_ISSUE) && !op_is_store(op_q);
    assign mem_write      = (state_q == S_ISSUE) && op_is_store(op_q);
    assign mem_byteenable = (state_q == S_ISSUE) ? al_be : '0;
    assign mem_address    = addr_q;
    assign mem_writedata  = wdata_q;
    assign resp_valid     = (state_q == S_RESP);
    assign resp_data      = resp_data_q;
    assign resp_err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a 32-bit and a 64-bit instance share
// stimulus and are checked one at a time against a byte-level reference model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel64;
    logic        req_valid, resp_ready, mem_waitrequest;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, req_rt, mem_readdata;

    logic        r32_ready, r32_rvalid, r32_err, r32_rd, r32_wr;
    logic [31:0] r32_data, r32_addr, r32_wdata;
    logic [3:0]  r32_be;
    logic        r64_ready, r64_rvalid, r64_err, r64_rd, r64_wr;
    logic [63:0] r64_data, r64_wdata;
    logic [31:0] r64_addr;
    logic [7:0]  r64_be;

    logic        o_ready, o_rvalid, o_err, o_rd, o_wr;
    logic [63:0] o_data, o_wdata;
    logic [31:0] o_addr;
    logic [7:0]  o_be;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && !sel64), .req_ready(r32_ready),
        .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .req_rt(req_rt[31:0]),
        .resp_valid(r32_rvalid), .resp_ready(resp_ready && !sel64),
        .resp_data(r32_data), .resp_err(r32_err),
        .mem_read(r32_rd), .mem_write(r32_wr), .mem_address(r32_addr),
        .mem_byteenable(r32_be), .mem_writedata(r32_wdata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata[31:0])
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel64), .req_ready(r64_ready),
        .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rt(req_rt),
        .resp_valid(r64_rvalid), .resp_ready(resp_ready && sel64),
        .resp_data(r64_data), .resp_err(r64_err),
        .mem_read(r64_rd), .mem_write(r64_wr), .mem_address(r64_addr),
        .mem_byteenable(r64_be), .mem_writedata(r64_wdata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
    );

    always_comb begin
        if (sel64) begin
            o_ready = r64_ready; o_rvalid = r64_rvalid; o_err = r64_err;
            o_rd = r64_rd; o_wr = r64_wr; o_data = r64_data;
            o_wdata = r64_wdata; o_addr = r64_addr; o_be = r64_be;
        end else begin
            o_ready = r32_ready; o_rvalid = r32_rvalid; o_err = r32_err;
            o_rd = r32_rd; o_wr = r32_wr; o_data = {32'h0, r32_data};
            o_wdata = {32'h0, r32_wdata}; o_addr = r32_addr; o_be = {4'h0, r32_be};
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, w64=%0b)", tag, got, exp, $time, sel64);
        end
    endtask

    // Reference: memory word viewed as a big-endian byte array, lane 0 first.
    function automatic void model(input int dw, input logic [3:0] op, input logic [31:0] addr,
                                  input logic [63:0] wdata, input logic [63:0] rt,
                                  input logic [63:0] rdata, output bit err,
                                  output logic [7:0] be, output logic [63:0] wlane,
                                  output logic [63:0] res);
        int lanes, off, sz, wb, b;
        logic [7:0]  mb [8];
        logic [63:0] val;
        logic [31:0] r32;
        bit st, sgn, part;
        lanes = dw / 8;
        off   = int'(addr[2:0]) % lanes;
        for (int k = 0; k < 8; k++) mb[k] = 8'h0;
        for (int k = 0; k < lanes; k++) mb[k] = 8'(rdata >> (dw - 8 - 8 * k));
        st   = op inside {OP_SB, OP_SH, OP_SW, OP_SD};
        sgn  = op inside {OP_LB, OP_LH, OP_LW};
        part = op inside {OP_LWL, OP_LWR};
        case (op)
            OP_LB, OP_LBU, OP_SB:                 sz = 1;
            OP_LH, OP_LHU, OP_SH:                 sz = 2;
            OP_LW, OP_LWU, OP_SW, OP_LWL, OP_LWR: sz = 4;
            OP_LD, OP_SD:                         sz = 8;
            default:                              sz = 0;
        endcase
        err = 1'b0; be = 8'h0; wlane = 64'h0; res = 64'h0;
        if (sz == 0 || 8 * sz > dw || (op == OP_LWU && dw == 32)) err = 1'b1;
        if (part) begin
`ifndef MEM_ACCESS_UNALIGNED_EN
            err = 1'b1;
`endif
        end else if (sz != 0 && (off % sz) != 0) begin
            err = 1'b1;
        end
        if (err) return;
        if (st) begin
            for (int i = 0; i < sz; i++) begin
                be[off + i] = 1'b1;
                wlane |= 64'(wdata[8 * (sz - 1 - i) +: 8]) << (dw - 8 - 8 * (off + i));
            end
        end else if (part) begin
            wb  = off - (off % 4);
            b   = off % 4;
            r32 = rt[31:0];
            if (op == OP_LWL) begin
                for (int i = 0; i <= 3 - b; i++) begin
                    r32[8 * (3 - i) +: 8] = mb[wb + b + i];
                    be[wb + b + i] = 1'b1;
                end
            end else begin
                for (int i = 0; i <= b; i++) begin
                    r32[8 * (b - i) +: 8] = mb[wb + i];
                    be[wb + i] = 1'b1;
                end
            end
            val = {{32{r32[31]}}, r32};
            res = (dw == 64) ? val : {32'h0, val[31:0]};
        end else begin
            val = 64'h0;
            for (int i = 0; i < sz; i++) begin
                val = (val << 8) | 64'(mb[off + i]);
                be[off + i] = 1'b1;
            end
            if (sgn && val[8 * sz - 1])
                for (int j = 8 * sz; j < 64; j++) val[j] = 1'b1;
            res = (dw == 64) ? val : {32'h0, val[31:0]};
        end
    endfunction

    task automatic run_txn(input bit w64, input logic [3:0] op, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rt,
                           input logic [63:0] rdata, input int waits, input int hold);
        bit          e_err, got_ready, st;
        logic [7:0]  e_be;
        logic [63:0] e_wl, e_res;
        logic [31:0] e_addr;
        int          dw, lat, strobes, cnt;
        dw     = w64 ? 64 : 32;
        model(dw, op, addr, wdata, rt, rdata, e_err, e_be, e_wl, e_res);
        e_addr = addr & ~32'(dw / 8 - 1);
        st     = op inside {OP_SB, OP_SH, OP_SW, OP_SD};
        sel64 = w64; req_op = op; req_addr = addr; req_wdata = wdata; req_rt = rt;
        mem_readdata = rdata; mem_waitrequest = 1'b1; resp_ready = 1'b0; req_valid = 1'b1;
        got_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_ready) begin got_ready = 1'b1; break; end
        end
        chk("accept_ready", 64'(o_ready), 64'h1);
        if (!got_ready) begin req_valid = 1'b0; return; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; strobes = 0; cnt = waits;
        for (int i = 0; i < 64 && !o_rvalid; i++) begin
            if (o_rd || o_wr) begin
                chk("mem_address", 64'(o_addr), 64'(e_addr));
                chk("byteenable", 64'(o_be), 64'(e_be));
                chk("strobe_kind", {62'h0, o_wr, o_rd}, st ? 64'h2 : 64'h1);
                if (st) chk("writedata", o_wdata, e_wl);
                strobes++;
                mem_waitrequest = (cnt > 0);
                if (cnt > 0) cnt--;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_valid", 64'(o_rvalid), 64'h1);
        chk("strobe_cycles", 64'(strobes), e_err ? 64'h0 : 64'(waits + 1));
        chk("latency", 64'(lat), e_err ? 64'h1 : 64'(waits + 2));
        chk("resp_err", 64'(o_err), 64'(e_err));
        if (!e_err) chk("resp_data", o_data, e_res);
        req_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(o_rvalid), 64'h1);
            chk("hold_err", 64'(o_err), 64'(e_err));
            if (!e_err) chk("hold_data", o_data, e_res);
            chk("hold_no_accept", 64'(o_ready), 64'h0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("back_to_idle", {63'h0, o_ready}, 64'h1);
        chk("resp_dropped", 64'(o_rvalid), 64'h0);
    endtask

    task automatic check_reset_outputs(input string where);
        chk({where, "_ready"}, 64'(o_ready), 64'h0);
        chk({where, "_rvalid"}, 64'(o_rvalid), 64'h0);
        chk({where, "_err"}, 64'(o_err), 64'h0);
        chk({where, "_strobes"}, {62'h0, o_rd, o_wr}, 64'h0);
        chk({where, "_be"}, 64'(o_be), 64'h0);
        chk({where, "_addr"}, 64'(o_addr), 64'h0);
        chk({where, "_wdata"}, o_wdata, 64'h0);
        chk({where, "_rdata"}, o_data, 64'h0);
    endtask

    task automatic reset_mid_access();
        bit got_ready;
        sel64 = 1'b0; req_op = OP_SW; req_addr = 32'h0000_0504; req_wdata = 64'h5A5A_1234;
        mem_waitrequest = 1'b1; resp_ready = 1'b0; req_valid = 1'b1;
        got_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_ready) begin got_ready = 1'b1; break; end
        end
        chk("rst_accept_ready", 64'(o_ready), 64'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_write", 64'(o_wr), 64'(got_ready));
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready_after_release", 64'(o_ready), 64'h1);
        chk("rst_no_response", 64'(o_rvalid), 64'h0);
        chk("rst_no_strobe", {62'h0, o_rd, o_wr}, 64'h0);
        mem_waitrequest = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_addr;
        logic [63:0] r_wd, r_rt, r_rd;
        reset = 1'b0; sel64 = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0;
        req_wdata = 64'h0; req_rt = 64'h0; resp_ready = 1'b0;
        mem_waitrequest = 1'b0; mem_readdata = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel64 = s[0];
            #1;
            check_reset_outputs("por");
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b0, OP_SB,  32'h0000_0103, 64'hAB, 64'h0, 64'h0, 0, 0);
        run_txn(1'b0, OP_LH,  32'h0000_0202, 64'h0, 64'h0, 64'h1234_F00D, 3, 0);
        run_txn(1'b0, OP_LW,  32'h0000_0301, 64'h0, 64'h0, 64'h0, 0, 1);
        run_txn(1'b0, OP_LWL, 32'h0000_0402, 64'h0, 64'hAABB_CCDD, 64'h1122_3344, 0, 0);
        run_txn(1'b0, OP_LWR, 32'h0000_0401, 64'h0, 64'hAABB_CCDD, 64'h1122_3344, 1, 0);
        run_txn(1'b1, OP_LBU, 32'h0000_0007, 64'h0, 64'h0, 64'h0102_0304_0506_0780, 0, 4);
        run_txn(1'b1, OP_SD,  32'h0000_0008, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 2, 0);
        run_txn(1'b0, OP_LD,  32'h0000_0008, 64'h0, 64'h0, 64'h0, 0, 0);
        reset_mid_access();

        for (int t = 0; t < 160; t++) begin
            r_op   = 4'($urandom_range(0, 12));
            r_addr = $urandom;
            r_wd   = {$urandom, $urandom};
            r_rt   = {$urandom, $urandom};
            r_rd   = {$urandom, $urandom};
            run_txn(1'($urandom_range(0, 1)), r_op, r_addr, r_wd, r_rt, r_rd,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, sets the memory bus width in bits; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, sets the byte-address width.
REQ-003 Derived constants SHALL be LANES = DATA_W/8 and OFF_W = log2(LANES).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req_valid / req_ready, input / output, 1 bit each: core request handshake.
REQ-007 Port req_op, input, 4 bits: mem_op_t code (LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD, LWL, LWR).
REQ-008 Port req_addr, input, ADDR_W bits: effective byte address.
REQ-009 Port req_wdata / req_rt, input, DATA_W bits each: store data and the old rt value used for the LWL/LWR merge.
REQ-010 Port resp_valid / resp_ready, output / input, 1 bit each: response handshake.
REQ-011 Port resp_data, output, DATA_W bits: register writeback value.
REQ-012 Port resp_err, output, 1 bit: address-error flag.
REQ-013 Ports mem_read and mem_write, output, 1 bit each: bus strobes.
REQ-014 Port mem_address, output, ADDR_W bits: always lane-aligned, low OFF_W bits zero.
REQ-015 Port mem_byteenable, output, LANES bits: per-lane write/read enables.
REQ-016 Port mem_writedata, output, DATA_W bits: lane-positioned store data.
REQ-017 Port mem_waitrequest and mem_readdata, input, 1 bit and DATA_W bits: bus stall and read data.

Function
REQ-018 Byte lane k (offset k) SHALL occupy bits [DATA_W-1-8k -: 8] (big-endian) and map to byteenable bit k.
REQ-019 The FSM SHALL have exactly three states: IDLE, ISSUE, RESP.
REQ-020 req_ready SHALL be high only in IDLE; acceptance occurs when req_valid and req_ready are high on the same edge.
REQ-021 On acceptance, req_op, the address offset, req_rt and the lane-shifted store data SHALL be registered.
REQ-022 Acceptance with an aligned address SHALL go to ISSUE; a misaligned one SHALL go to RESP with resp_err=1 and no bus strobe.
REQ-023 Misaligned means: halfword offset not a multiple of 2, word not a multiple of 4, doubleword not a multiple of 8; LB/SB/LWL/LWR are never misaligned.
REQ-024 In ISSUE, mem_read or mem_write SHALL be held with address, byteenable and writedata stable while mem_waitrequest=1.
REQ-025 The first ISSUE cycle with mem_waitrequest=0 completes the access; the next state is RESP.
REQ-026 Load data SHALL be captured from mem_readdata in the completing cycle using the registered offset.
REQ-027 Captured load data SHALL be sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to DATA_W.
REQ-028 LWL SHALL merge lanes offset..3 of the aligned word into the register's most-significant bytes, keeping the low bytes of req_rt.
REQ-029 LWR SHALL merge lanes 0..offset into the register's least-significant bytes, keeping the high bytes of req_rt.
REQ-030 LWL/LWR SHALL operate on the 32-bit word containing the address; when DATA_W=64 the merged result is sign-extended from bit 31.
REQ-031 A store completes in RESP with resp_data = 0.
REQ-032 In RESP, resp_valid=1 and resp_data/resp_err SHALL be held stable until resp_ready=1, then return to IDLE.
REQ-033 Minimum latency SHALL be 2 cycles from acceptance to resp_valid (zero-wait bus); each wait cycle adds one.
REQ-034 LD, SD and LWU with DATA_W=32 SHALL be rejected as resp_err=1.

Reset
REQ-035 Reset assertion SHALL force IDLE immediately, even mid-access; the access is abandoned and no response is produced.
REQ-036 During reset, req_ready=0, resp_valid=0, resp_err=0, mem_read=0, mem_write=0, mem_byteenable=0, and mem_address, mem_writedata and resp_data are 0.
REQ-037 Release of reset SHALL take effect on the first rising edge of clk.

Configuration
REQ-038 Macro MEM_ACCESS_UNALIGNED_EN SHALL compile LWL/LWR support in; without the macro, LWL/LWR SHALL return resp_err=1 and issue no bus access.

Structure
REQ-039 mem_op_t, size decode functions, LANES/OFF_W helpers and FSM state encoding SHALL live in package mem_access_pkg.
REQ-040 Lane steering/extension/merge SHALL be a combinational sub-module mem_lane_align.

Verification
REQ-041 Bench: SB addr 0x103, wdata 0xAB, no waits -> byteenable 4'b1000, writedata 0x000000AB, mem_address 0x100, resp_valid 2 cycles after acceptance.
REQ-042 Bench: LH addr 0x202, readdata 0x1234F00D, 3 wait cycles -> resp_data 0xFFFFF00D, resp_valid 5 cycles after acceptance.
REQ-043 Bench: LW addr 0x301 -> resp_err=1, no mem_read pulse, resp_valid the next cycle.
REQ-044 Bench: LWL addr 0x402, readdata 0x11223344, rt 0xAABBCCDD -> resp_data 0x3344CCDD; with the macro undefined -> resp_err=1.
REQ-045 Bench: reset asserted during ISSUE with mem_waitrequest=1 -> strobes low immediately; req_ready=1 the first cycle after release.
REQ-046 Bench: DATA_W=64, LBU addr 0x7, readdata lane 7 = 0x80 -> resp_data 0x80; resp_ready held low 4 cycles -> resp_data stable and no new acceptance.
